// File: rtl/gcd_lcm_coproc.sv
// gcd_lcm_coproc: multi-cycle GCD/LCM coprocessor for the custom gcd/lcm
// instructions. GCD uses the binary (Stein) algorithm, one step per cycle.
// LCM reuses that GCD, then does a restoring division a0/g (WIDTH cycles)
// and a truncated multiply by b0.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    decoder Start (level, held while stalled)
//   lcm_sel  0 = gcd, 1 = lcm; sampled at accept
//   src_a    rs1 operand; sampled at accept
//   src_b    rs2 operand; sampled at accept
//   result   registered result; held until the next accept
//   done     one-cycle pulse with result valid
//   busy     high in GCD and DIV states
//   stall    (start & IDLE) | busy; freezes PC/IF/ID
module gcd_lcm_coproc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             lcm_sel,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             stall
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, GCD, DIV, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, a_nxt, b, b_nxt;
  logic [WIDTH-1:0] a0, a0_nxt, b0, b0_nxt;
  logic [WIDTH-1:0] g, g_nxt, result_nxt;
  logic             op, op_nxt;
  logic [CW-1:0]    k, k_nxt, cnt, cnt_nxt;

  // During DIV, a is reused as the dividend/quotient shift register and
  // b as the partial remainder, so no extra WIDTH-wide registers are needed.
  logic [WIDTH:0]   rem_sh, diff;
  logic             qbit;
  logic [WIDTH-1:0] rem, quo;

  assign rem_sh = {b, a[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, g};
  assign qbit   = ~diff[WIDTH];
  assign rem    = qbit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo    = {a[WIDTH-2:0], qbit};

  assign busy  = (state == GCD) || (state == DIV);
  assign done  = (state == DONE);
  assign stall = (start && (state == IDLE)) || busy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      a0     <= '0;
      b0     <= '0;
      g      <= '0;
      op     <= 1'b0;
      k      <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      state  <= state_nxt;
      a      <= a_nxt;
      b      <= b_nxt;
      a0     <= a0_nxt;
      b0     <= b0_nxt;
      g      <= g_nxt;
      op     <= op_nxt;
      k      <= k_nxt;
      cnt    <= cnt_nxt;
      result <= result_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    a_nxt      = a;
    b_nxt      = b;
    a0_nxt     = a0;
    b0_nxt     = b0;
    g_nxt      = g;
    op_nxt     = op;
    k_nxt      = k;
    cnt_nxt    = cnt;
    result_nxt = result;
    case (state)
      IDLE: begin
        if (start) begin
          a_nxt  = src_a;
          b_nxt  = src_b;
          a0_nxt = src_a;
          b0_nxt = src_b;
          op_nxt = lcm_sel;
          k_nxt  = '0;
          if ((src_a == '0) || (src_b == '0)) begin
            result_nxt = lcm_sel ? '0 : (src_a | src_b);
            state_nxt  = DONE;
          end else begin
            state_nxt = GCD;
          end
        end
      end
      GCD: begin
        if (a == b) begin
          g_nxt = a << k;
          if (op) begin
            a_nxt     = a0;
            b_nxt     = '0;
            cnt_nxt   = '0;
            state_nxt = DIV;
          end else begin
            result_nxt = a << k;
            state_nxt  = DONE;
          end
        end else if (!a[0] && !b[0]) begin
          a_nxt = a >> 1;
          b_nxt = b >> 1;
          k_nxt = k + 1'b1;
        end else if (!a[0]) begin
          a_nxt = a >> 1;
        end else if (!b[0]) begin
          b_nxt = b >> 1;
        end else if (a > b) begin
          a_nxt = (a - b) >> 1;
        end else begin
          b_nxt = (b - a) >> 1;
        end
      end
      DIV: begin
        a_nxt   = quo;
        b_nxt   = rem;
        cnt_nxt = cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          result_nxt = quo * b0;
          state_nxt  = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// Directed testbench for gcd_lcm_coproc: expected results come from a
// Euclid-based reference model and are queued at issue, popped at done.
module tb_gcd_lcm_coproc;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         start = 1'b0;
  logic         lcm_sel = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic [W-1:0] result;
  logic         done;
  logic         busy;
  logic         stall;

  gcd_lcm_coproc #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .lcm_sel (lcm_sel),
    .src_a   (src_a),
    .src_b   (src_b),
    .result  (result),
    .done    (done),
    .busy    (busy),
    .stall   (stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    int unsigned  lat;
  } exp_t;

  exp_t         sb[$];
  int           tests = 0;
  int           fails = 0;
  int           ndone = 0;
  int           nexp_done = 0;
  logic [W-1:0] last_res = '0;

  always @(negedge clk) if (done) ndone++;

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] p, q, t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  function automatic logic [W-1:0] ref_lcm(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] q;
    if (x == 0 || y == 0) return '0;
    q = x / ref_gcd(x, y);
    return q * y;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction; start stays high through DONE like a stalled core.
  task automatic run_op(input string tag, input logic sel, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int unsigned lat,
                        input int unsigned maxlat, input bit scramble);
    exp_t        e;
    int unsigned cnt;
    e.res = sel ? ref_lcm(a, b) : ref_gcd(a, b);
    e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    start   = 1'b1;
    lcm_sel = sel;
    src_a   = a;
    src_b   = b;
    #1;
    check({tag, ":stall_accept"}, stall, 1);
    @(posedge clk);
    cnt = 0;
    while (1) begin
      @(negedge clk);
      cnt++;
      if (done || cnt > maxlat) break;
      check({tag, ":busy"}, busy, 1);
      check({tag, ":stall"}, stall, 1);
      if (scramble) begin
        lcm_sel = ~lcm_sel;
        src_a   = $urandom;
        src_b   = $urandom;
      end
    end
    e = sb.pop_front();
    if (!done) begin
      check({tag, ":timeout_done"}, done, 1);
    end else begin
      nexp_done++;
      check({tag, ":result"}, result, e.res);
      check({tag, ":stall_done"}, stall, 0);
      check({tag, ":busy_done"}, busy, 0);
      if (e.lat != 0) check({tag, ":latency"}, cnt, e.lat);
      else            check({tag, ":latency_bound"}, cnt <= maxlat, 1);
      last_res = e.res;
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    start = 1'b0;
    #1;
    check("idle:stall", stall, 0);
    check("idle:busy", busy, 0);
    check("idle:done", done, 0);
    check("idle:result_hold", result, last_res);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_mid(input string tag, input logic sel, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int wcyc);
    @(negedge clk);
    start   = 1'b1;
    lcm_sel = sel;
    src_a   = a;
    src_b   = b;
    @(posedge clk);
    repeat (wcyc) @(negedge clk);
    check({tag, ":busy_before"}, busy, 1);
    start   = 1'b0;
    reset_n = 1'b0;
    #1;
    check({tag, ":done"}, done, 0);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":result"}, result, 0);
    check({tag, ":stall"}, stall, 0);
    @(negedge clk);
    check({tag, ":done_held"}, done, 0);
    reset_n  = 1'b1;
    last_res = '0;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1;
    check("rst:result", result, 0);
    check("rst:done", done, 0);
    check("rst:busy", busy, 0);
    check("rst:stall_lo", stall, 0);
    start = 1'b1;
    #1;
    check("rst:stall_hi", stall, 1);
    start = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    run_op("gcd_12_18", 1'b0, 32'd12, 32'd18, 5, 5, 1'b0);
    idle(2);
    run_op("lcm_4_6", 1'b1, 32'd4, 32'd6, 37, 37, 1'b0);
    idle(1);
    run_op("gcd_0_7", 1'b0, 32'd0, 32'd7, 1, 1, 1'b0);
    run_op("lcm_9_0", 1'b1, 32'd9, 32'd0, 1, 1, 1'b0);
    run_op("gcd_0_0", 1'b0, 32'd0, 32'd0, 1, 1, 1'b0);
    idle(1);
    run_op("gcd_worst", 1'b0, 32'd1, 32'hFFFF_FFFF, 0, 66, 1'b0);
    run_op("lcm_trunc", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 98, 1'b0);
    run_op("gcd_b2b", 1'b0, 32'd100, 32'd75, 0, 66, 1'b0);
    run_op("lcm_scramble", 1'b1, 32'd21, 32'd6, 0, 98, 1'b1);
    run_op("gcd_scramble", 1'b0, 32'd1071, 32'd462, 0, 66, 1'b1);
    idle(2);
    reset_mid("rst_gcd", 1'b0, 32'hFFFF_FFFF, 32'd1, 10);
    run_op("gcd_48_180", 1'b0, 32'd48, 32'd180, 0, 66, 1'b0);
    idle(1);
    reset_mid("rst_div", 1'b1, 32'd4, 32'd6, 10);
    run_op("gcd_48_180_b", 1'b0, 32'd48, 32'd180, 0, 66, 1'b0);
    idle(3);

    check("done_pulse_count", ndone, nexp_done);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
